// File: rtl/pcihellocore_led_pulse_pio.sv
// pcihellocore_led_pulse_pio
//
// Avalon-MM output PIO with timed pulses. The host can write the output
// register directly (DATA) or set and clear individual bits (SET, CLEAR).
// It can also fire pulses (PULSE). A pulsed bit stays high for exactly
// PULSE_CYCLES clocks and then clears itself.
//
// Register map (word address):
//   0  DATA   write: out_port = wd, cancels any pulse      read: out_port
//   1  SET    write: out_port |= wd, bits become permanent read: pulse_mask
//   2  CLEAR  write: out_port &= ~wd, bits leave the pulse read: count
//   3  PULSE  write: out_port |= wd, (re)start the timer   read: pulse_active
//
// Ports:
//   clk         system clock, rising edge
//   reset       synchronous, active-high
//   address     register word address
//   chipselect  slave select
//   write_n     active-low write strobe
//   writedata   write data; bits at DATA_WIDTH and above are ignored
//   readdata    read data, registered every cycle (1-cycle latency)
//   out_port    driven output lines
//
// PULSE_CYCLES must be >= 1 and PULSE_CYCLES-1 must fit in CNT_WIDTH bits.
module pcihellocore_led_pulse_pio #(
    parameter int                    DATA_WIDTH   = 32,
    parameter logic [DATA_WIDTH-1:0] RESET_VALUE  = '0,
    parameter int                    PULSE_CYCLES = 50000000,
    parameter int                    CNT_WIDTH    = 32
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [1:0]            address,
    input  logic                  chipselect,
    input  logic                  write_n,
    input  logic [31:0]           writedata,
    output logic [31:0]           readdata,
    output logic [DATA_WIDTH-1:0] out_port
);

    localparam logic [1:0] ADDR_DATA  = 2'd0;
    localparam logic [1:0] ADDR_SET   = 2'd1;
    localparam logic [1:0] ADDR_CLEAR = 2'd2;
    localparam logic [1:0] ADDR_PULSE = 2'd3;

    // The counter is loaded with PULSE_CYCLES-1. Expiry happens on the edge
    // after it reaches zero, so the bit stays high for PULSE_CYCLES cycles.
    localparam logic [CNT_WIDTH-1:0] COUNT_LOAD = CNT_WIDTH'(PULSE_CYCLES - 1);

    logic [DATA_WIDTH-1:0] wd;
    logic                  write_en;

    logic [DATA_WIDTH-1:0] out_reg, out_nxt;
    logic [DATA_WIDTH-1:0] mask_reg, mask_nxt;
    logic                  active_reg, active_nxt;
    logic [CNT_WIDTH-1:0]  count_reg, count_nxt;
    logic [31:0]           read_reg, read_nxt;

    assign wd       = writedata[DATA_WIDTH-1:0];
    assign write_en = chipselect & ~write_n;

    generate
        if (DATA_WIDTH < 32) begin : g_unused_wd
            logic unused_writedata_hi;
            assign unused_writedata_hi = ^writedata[31:DATA_WIDTH];
        end
    endgenerate

    // Expiry (or decrement) is evaluated first. A write in the same cycle
    // then acts on the post-expiry values. This is how a DATA or SET write
    // keeps its bits, and how a PULSE write starts a fresh pulse.
    always_comb begin
        out_nxt    = out_reg;
        mask_nxt   = mask_reg;
        active_nxt = active_reg;
        count_nxt  = count_reg;

        if (active_reg) begin
            if (count_reg == '0) begin
                out_nxt    = out_reg & ~mask_reg;
                mask_nxt   = '0;
                active_nxt = 1'b0;
            end else begin
                count_nxt = count_reg - CNT_WIDTH'(1);
            end
        end

        if (write_en) begin
            case (address)
                ADDR_DATA: begin
                    out_nxt    = wd;
                    mask_nxt   = '0;
                    active_nxt = 1'b0;
                end
                ADDR_SET: begin
                    out_nxt  = out_nxt | wd;
                    mask_nxt = mask_nxt & ~wd;
                end
                ADDR_CLEAR: begin
                    out_nxt  = out_nxt & ~wd;
                    mask_nxt = mask_nxt & ~wd;
                    if (mask_nxt == '0) begin
                        active_nxt = 1'b0;
                    end
                end
                ADDR_PULSE: begin
                    // A zero-valued pulse write must not restart an idle timer.
                    if (wd != '0) begin
                        out_nxt    = out_nxt | wd;
                        mask_nxt   = mask_nxt | wd;
                        count_nxt  = COUNT_LOAD;
                        active_nxt = 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    // The read mux uses the register values from before this edge.
    always_comb begin
        read_nxt = '0;
        case (address)
            ADDR_DATA:  read_nxt = 32'(out_reg);
            ADDR_SET:   read_nxt = 32'(mask_reg);
            ADDR_CLEAR: read_nxt = 32'(count_reg);
            ADDR_PULSE: read_nxt = {31'b0, active_reg};
            default:    read_nxt = '0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            out_reg    <= RESET_VALUE;
            mask_reg   <= '0;
            active_reg <= 1'b0;
            count_reg  <= '0;
            read_reg   <= '0;
        end else begin
            out_reg    <= out_nxt;
            mask_reg   <= mask_nxt;
            active_reg <= active_nxt;
            count_reg  <= count_nxt;
            read_reg   <= read_nxt;
        end
    end

    assign out_port = out_reg;
    assign readdata = read_reg;

endmodule
